// File: rtl/fpu_pkg.sv
// Shared op codes, fcsr field encodings and FSM state type for the fpu issue path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

    localparam logic [5:0] FADD      = 6'd0;
    localparam logic [5:0] FSUB      = 6'd1;
    localparam logic [5:0] FCVT_S_W  = 6'd4;
    localparam logic [5:0] FCVT_S_WU = 6'd5;
    localparam logic [5:0] FCVT_W_S  = 6'd6;
    localparam logic [5:0] FCVT_WU_S = 6'd7;
    localparam logic [5:0] FCLASS    = 6'd8;
    localparam logic [5:0] FMIN      = 6'd9;
    localparam logic [5:0] FMAX      = 6'd10;
    localparam logic [5:0] FSGNJ     = 6'd11;
    localparam logic [5:0] FSGNJN    = 6'd12;
    localparam logic [5:0] FSGNJX    = 6'd13;
    localparam logic [5:0] FLT       = 6'd14;
    localparam logic [5:0] FLE       = 6'd15;
    localparam logic [5:0] FEQ       = 6'd16;

    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [2:0] RM_DYN = 3'd7;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Encodings 5 and 6 are reserved rounding modes.
    function automatic logic rm_reserved(input logic [2:0] rm);
        return (rm == 3'd5) || (rm == 3'd6);
    endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Classifies an fpu op: execute latency, integer-file destination, illegal op/rounding mode.
// Latency: combinational.
// Backpressure: none.
module fpu_op_decode
    import fpu_pkg::*;
#(
    parameter int LAT_ARITH = 2,
    parameter int LAT_CVT   = 2,
    parameter int LAT_MISC  = 1
) (
    input  logic [5:0]       op,
    input  logic [2:0]       rm_eff,
    output logic [CNT_W-1:0] lat,
    output logic             wb_int,
    output logic             illegal
);

    always_comb begin
        lat     = '0;
        wb_int  = 1'b0;
        illegal = 1'b0;
        if (op <= FSUB) begin
            lat = CNT_W'(LAT_ARITH);
        end else if (op >= FCVT_S_W && op <= FCVT_WU_S) begin
            lat = CNT_W'(LAT_CVT);
        end else if (op >= FCLASS && op <= FEQ) begin
            lat = CNT_W'(LAT_MISC);
        end else begin
            illegal = 1'b1;
        end
        if (rm_reserved(rm_eff)) begin
            illegal = 1'b1;
        end
        wb_int = (op == FCVT_W_S) || (op == FCVT_WU_S) || (op == FCLASS) ||
                 (op == FLT) || (op == FLE) || (op == FEQ);
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one F-extension op to the fpu, waits its latency, returns the result on writeback; owns fcsr.
// Latency: accept to wb_valid = LAT(op)+1 cycles (illegal ops: 1 cycle).
// Backpressure: req_ready only in IDLE; wb outputs hold until wb_ready.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int FLEN      = 32,
    parameter int LAT_ARITH = 2,
    parameter int LAT_CVT   = 2,
    parameter int LAT_MISC  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      req_op,
    input  logic [FLEN-1:0] req_rs1,
    input  logic [FLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic [2:0]      req_rm,
    output logic [5:0]      fpu_op,
    output logic [FLEN-1:0] fpu_rs1,
    output logic [FLEN-1:0] fpu_rs2,
    output logic [31:0]     fpu_fcsr,
    input  logic [FLEN-1:0] fpu_result,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [FLEN-1:0] wb_data,
    output logic            wb_int,
    output logic            wb_illegal,
    input  logic            csr_we,
    input  logic [7:0]      csr_wdata,
    output logic [7:0]      fcsr
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       frm;
    logic [4:0]       fflags;
    logic [2:0]       iss_rm;
    logic [4:0]       iss_flags;

    logic [2:0]       rm_eff;
    logic [CNT_W-1:0] dec_lat;
    logic             dec_int;
    logic             dec_illegal;

    assign rm_eff   = (req_rm == RM_DYN) ? frm : req_rm;
    assign fcsr     = {frm, fflags};
    assign fpu_fcsr = {24'b0, iss_rm, iss_flags};

    fpu_op_decode #(
        .LAT_ARITH (LAT_ARITH),
        .LAT_CVT   (LAT_CVT),
        .LAT_MISC  (LAT_MISC)
    ) u_decode (
        .op      (req_op),
        .rm_eff  (rm_eff),
        .lat     (dec_lat),
        .wb_int  (dec_int),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            cnt        <= '0;
            frm        <= '0;
            fflags     <= '0;
            iss_rm     <= '0;
            iss_flags  <= '0;
            fpu_op     <= '0;
            fpu_rs1    <= '0;
            fpu_rs2    <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_int     <= 1'b0;
            wb_illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        fpu_op    <= req_op;
                        fpu_rs1   <= req_rs1;
                        fpu_rs2   <= req_rs2;
                        iss_rm    <= rm_eff;
                        iss_flags <= fflags;
                        wb_rd     <= req_rd;
                        wb_int    <= dec_int;
                        req_ready <= 1'b0;
                        if (dec_illegal) begin
                            wb_illegal       <= 1'b1;
                            wb_data          <= '0;
                            wb_valid         <= 1'b1;
                            fflags[FFLAG_NV] <= 1'b1;
                            state            <= S_WB;
                        end else begin
                            wb_illegal <= 1'b0;
                            cnt        <= dec_lat - CNT_W'(1);
                            state      <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        wb_data  <= fpu_result;
                        wb_valid <= 1'b1;
                        state    <= S_WB;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        wb_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    wb_valid  <= 1'b0;
                end
            endcase
            // A software write overrides any flag set by this cycle's illegal op.
            if (csr_we) begin
                frm    <= csr_wdata[7:5];
                fflags <= csr_wdata[4:0];
            end
        end
    end

endmodule
